// File: rtl/ingress_drr_sched_pkg.sv
// Shared types and constants for the ingress deficit-round-robin scheduler.
// Holds the one-hot state encoding and the saturating deficit arithmetic.
package ingress_drr_sched_pkg;

    localparam int NPORT        = 4;
    localparam int LEN_W        = 13;
    localparam int DEF_W        = 14;
    localparam int TMO_W        = 14;
    localparam int PTR_W        = $clog2(NPORT);
    localparam int QUANTUM_DFLT = 1536;
    localparam int MAX_FRAME    = 1518;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_SCAN  = 4'b0010,
        S_GRANT = 4'b0100,
        S_WAIT  = 4'b1000
    } state_e;

    // Deficit accumulation clamps at all-ones instead of wrapping.
    function automatic logic [DEF_W-1:0] sat_add(input logic [DEF_W-1:0] a,
                                                  input logic [DEF_W-1:0] b);
        logic [DEF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DEF_W] ? {DEF_W{1'b1}} : s[DEF_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NPORT - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/ingress_drr_sched_if.sv
// Request/grant bundle between the MAC ingress ports and the DRR scheduler.
// Handshake: the scheduler drives a one-hot grant with grant_vld on its first cycle and holds it
// until the mux pulses done for one cycle (or the watchdog fires); done with no grant is ignored.
interface ingress_drr_sched_if;
    import ingress_drr_sched_pkg::*;

    logic [NPORT-1:0]       req;
    logic [NPORT*LEN_W-1:0] hol_len;
    logic [NPORT-1:0]       port_en;
    logic                   bp;
    logic                   done;
    logic [NPORT-1:0]       grant;
    logic [PTR_W-1:0]       grant_bin;
    logic                   grant_vld;
    logic                   busy;
    logic                   tmo_err;

    modport master (
        output req, hol_len, port_en, bp, done,
        input  grant, grant_bin, grant_vld, busy, tmo_err
    );

    modport slave (
        input  req, hol_len, port_en, bp, done,
        output grant, grant_bin, grant_vld, busy, tmo_err
    );

endinterface

// File: rtl/ingress_drr_sched.sv
// Byte-fair deficit-round-robin scheduler choosing which ingress port moves its next frame.
// One grant outstanding at a time; a watchdog drops the grant if done never arrives.
module ingress_drr_sched
    import ingress_drr_sched_pkg::*;
#(
    parameter int QUANTUM = QUANTUM_DFLT
) (
    input  logic                   clk_sys,
    input  logic                   rst_sys,
    ingress_drr_sched_if.slave     sched,
    output state_e                 dbg_state_o,
    output logic [PTR_W-1:0]       dbg_ptr_o,
    output logic [NPORT*DEF_W-1:0] dbg_deficit_o
);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              fresh_q, fresh_d;
    logic [TMO_W-1:0]  wd_q, wd_d;
    logic [DEF_W-1:0]  deficit_w [NPORT];

    logic [NPORT-1:0]  elig;
    logic [LEN_W-1:0]  len_sel;
    logic [DEF_W-1:0]  credit;
    logic              fits;
    logic              def_we;
    logic [DEF_W-1:0]  def_wdata;
    logic              tmo_fire;
    logic              granting;

    assign elig     = sched.req & sched.port_en;
    assign len_sel  = sched.hol_len[ptr_q*LEN_W +: LEN_W];
    // Single credit path shared by all ports, steered by ptr.
    assign credit   = sat_add(deficit_w[ptr_q], fresh_q ? DEF_W'(QUANTUM) : '0);
    assign fits     = (credit >= DEF_W'(len_sel));

    for (genvar p = 0; p < NPORT; p++) begin : g_def
        logic [DEF_W-1:0] def_q;
        always_ff @(posedge clk_sys) begin
            if (rst_sys) begin
                def_q <= '0;
            end else if (def_we && (ptr_q == PTR_W'(p))) begin
                def_q <= def_wdata;
            end
        end
        assign deficit_w[p]                  = def_q;
        assign dbg_deficit_o[p*DEF_W +: DEF_W] = def_q;
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            fresh_q <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fresh_q <= fresh_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        fresh_d   = fresh_q;
        wd_d      = wd_q;
        def_we    = 1'b0;
        def_wdata = '0;
        tmo_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((elig != '0) && !sched.bp) state_d = S_SCAN;
            end
            S_SCAN: begin
                def_we = 1'b1;
                if (!elig[ptr_q]) begin
                    def_wdata = '0;
                    ptr_d     = next_ptr(ptr_q);
                    fresh_d   = 1'b1;
                    if (elig == '0) state_d = S_IDLE;
                end else if (fits) begin
                    def_wdata = credit - DEF_W'(len_sel);
                    fresh_d   = 1'b0;
                    state_d   = S_GRANT;
                end else begin
                    def_wdata = credit;
                    ptr_d     = next_ptr(ptr_q);
                    fresh_d   = 1'b1;
                end
            end
            S_GRANT: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a simultaneous watchdog expiry.
                if (sched.done) begin
                    wd_d    = '0;
                    state_d = S_IDLE;
                end else if (&wd_q) begin
                    tmo_fire  = 1'b1;
                    wd_d      = '0;
                    def_we    = 1'b1;
                    def_wdata = '0;
                    ptr_d     = next_ptr(ptr_q);
                    fresh_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign granting        = (state_q == S_GRANT) || (state_q == S_WAIT);
    assign sched.grant     = granting ? ({{(NPORT-1){1'b0}}, 1'b1} << ptr_q) : '0;
    assign sched.grant_bin = granting ? ptr_q : '0;
    assign sched.grant_vld = (state_q == S_GRANT);
    assign sched.busy      = (state_q != S_IDLE);
    assign sched.tmo_err   = tmo_fire;

    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_ingress_drr_sched.sv
// Directed bench for the ingress DRR scheduler: latency, byte fairness, masking,
// backpressure, watchdog and mid-grant reset, all with hand-computed expectations.
module tb_ingress_drr_sched;
    import ingress_drr_sched_pkg::*;

    localparam int DONE_DLY = 5;

    logic clk_sys = 1'b0;
    logic rst_sys = 1'b1;
    always #5 clk_sys = ~clk_sys;

    ingress_drr_sched_if bus ();

    state_e                 dbg_state;
    logic [PTR_W-1:0]       dbg_ptr;
    logic [NPORT*DEF_W-1:0] dbg_def;

    ingress_drr_sched dut (
        .clk_sys       (clk_sys),
        .rst_sys       (rst_sys),
        .sched         (bus.slave),
        .dbg_state_o   (dbg_state),
        .dbg_ptr_o     (dbg_ptr),
        .dbg_deficit_o (dbg_def)
    );

    int checks = 0;
    int errors = 0;
    logic [PTR_W-1:0] exp_q[$];

    int lens  [NPORT];
    int bytes [NPORT];
    int snap  [NPORT];
    int gcnt  [NPORT];
    int done_cnt;
    int run_port;
    int run_len;
    int runs_chk;
    int max_def2;

    function automatic int def_of(input int p);
        return int'(dbg_def[p*DEF_W +: DEF_W]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
        lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
        for (int p = 0; p < NPORT; p++) bus.hol_len[p*LEN_W +: LEN_W] = LEN_W'(lens[p]);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst_sys     = 1'b1;
        bus.req     = '0;
        bus.port_en = '0;
        bus.bp      = 1'b0;
        bus.done    = 1'b0;
        set_lens(0, 0, 0, 0);
        done_cnt = 0;
        run_port = -1;
        run_len  = 0;
        runs_chk = 0;
        max_def2 = 0;
        for (int p = 0; p < NPORT; p++) begin
            bytes[p] = 0; snap[p] = 0; gcnt[p] = 0;
        end
        exp_q.delete();
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_sys = 1'b0;
    endtask

    task automatic wait_vld(input int limit, output int cyc, output bit found);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < limit) begin
            @(negedge clk_sys);
            bus.done = 1'b0;
            cyc++;
            if (bus.grant_vld) found = 1'b1;
        end
    endtask

    // Acts as the ingress mux: answers each grant with done DONE_DLY cycles later.
    task automatic serve(input int ncyc, input bit track);
        int p;
        int e;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_sys);
            bus.done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) bus.done = 1'b1;
            end
            check("grant_onehot0", 32'($onehot0(bus.grant)), 1);
            if (def_of(2) > max_def2) max_def2 = def_of(2);
            if (bus.grant_vld) begin
                p = int'(bus.grant_bin);
                check("grant_matches_bin", 32'(bus.grant), 32'(1 << p));
                gcnt[p]++;
                bytes[p] += lens[p];
                if (exp_q.size() > 0) begin
                    e = int'(exp_q.pop_front());
                    check("grant_seq", p, e);
                end
                if (track) begin
                    if (p == run_port) begin
                        run_len++;
                    end else begin
                        if (run_port == 1) begin
                            check("p1_run_len", run_len, 24);
                            runs_chk++;
                        end
                        run_port = p;
                        run_len  = 1;
                    end
                    if (p == 0) snap = bytes;
                end
                done_cnt = DONE_DLY;
            end
        end
    endtask

    initial begin
        int  cyc;
        bit  found;
        int  d01;

        // Reset state
        do_reset();
        check("rst_grant", bus.grant, 0);
        check("rst_grant_bin", bus.grant_bin, 0);
        check("rst_grant_vld", bus.grant_vld, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_tmo_err", bus.tmo_err, 0);
        check("rst_state", dbg_state, S_IDLE);
        for (int p = 0; p < NPORT; p++) check("rst_deficit", def_of(p), 0);

        // Single port, 64-byte frames
        bus.port_en = 4'b1111;
        set_lens(64, 0, 0, 0);
        bus.req = 4'b0001;
        wait_vld(20, cyc, found);
        check("t1_found", found, 1);
        check("t1_latency", cyc, 2);
        check("t1_grant", bus.grant, 4'b0001);
        check("t1_deficit0", def_of(0), 1472);
        done_cnt = DONE_DLY;
        for (int i = 0; i < 20; i++) exp_q.push_back('0);
        serve(200, 1'b0);
        check("t1_all_grants_seen", exp_q.size(), 0);

        // Oversized frame needs six visits: 6*1536 - 8000 = 1216 left
        do_reset();
        bus.port_en = 4'b1111;
        set_lens(8000, 0, 0, 0);
        bus.req = 4'b0001;
        wait_vld(100, cyc, found);
        check("t1b_found", found, 1);
        check("t1b_latency", cyc, 22);
        check("t1b_deficit0", def_of(0), 1216);

        // Byte fairness with all four ports backlogged
        do_reset();
        bus.port_en = 4'b1111;
        set_lens(1500, 64, 64, 64);
        bus.req = 4'b1111;
        serve(10000, 1'b1);
        check("t2_p1_runs_seen", 32'(runs_chk > 2), 1);
        check("t2_snap_p2_eq_p1", snap[2], snap[1]);
        check("t2_snap_p3_eq_p1", snap[3], snap[1]);
        d01 = snap[0] - snap[1];
        if (d01 < 0) d01 = -d01;
        check("t2_within_quantum", 32'(d01 <= QUANTUM_DFLT), 1);
        check("t2_p0_served", 32'(snap[0] >= 15 * 1500), 1);

        // Port 2 masked off
        do_reset();
        bus.port_en = 4'b1011;
        set_lens(64, 64, 64, 64);
        bus.req = 4'b1111;
        serve(2000, 1'b0);
        check("t3_p2_grants", gcnt[2], 0);
        check("t3_p2_deficit_max", max_def2, 0);
        check("t3_p3_served", 32'(gcnt[3] > 0), 1);
        check("t3_p0_served", 32'(gcnt[0] > 0), 1);

        // Backpressure holds the scheduler in IDLE; stray done is ignored
        do_reset();
        bus.port_en = 4'b1111;
        set_lens(64, 64, 64, 64);
        bus.bp  = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            bus.done = (i == 4);
            check("t4_busy_low", bus.busy, 0);
            check("t4_no_grant", bus.grant, 0);
        end
        @(negedge clk_sys);
        bus.done = 1'b0;
        bus.bp   = 1'b0;
        wait_vld(10, cyc, found);
        check("t4_found", found, 1);
        check("t4_latency", cyc, 2);
        check("t4_grant", bus.grant, 4'b0001);

        // Watchdog expiry
        do_reset();
        bus.port_en = 4'b1111;
        set_lens(64, 64, 0, 0);
        bus.req = 4'b0011;
        wait_vld(10, cyc, found);
        check("t5_found", found, 1);
        check("t5_grant", bus.grant, 4'b0001);
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 20000) begin
            @(negedge clk_sys);
            cyc++;
            if (bus.tmo_err) found = 1'b1;
        end
        check("t5_tmo_seen", found, 1);
        check("t5_tmo_cycles", cyc, 16384);
        @(negedge clk_sys);
        check("t5_tmo_pulse_1cyc", bus.tmo_err, 0);
        check("t5_grant_dropped", bus.grant, 0);
        check("t5_deficit0_cleared", def_of(0), 0);
        wait_vld(10, cyc, found);
        check("t5_next_found", found, 1);
        check("t5_next_grant", bus.grant, 4'b0010);

        // done coinciding with watchdog expiry wins
        do_reset();
        bus.port_en = 4'b1111;
        set_lens(64, 64, 0, 0);
        bus.req = 4'b0011;
        wait_vld(10, cyc, found);
        check("t5b_found", found, 1);
        found = 1'b0;
        for (int i = 0; i < 16383; i++) begin
            @(negedge clk_sys);
            if (bus.tmo_err) found = 1'b1;
        end
        check("t5b_no_early_tmo", found, 0);
        @(negedge clk_sys);
        bus.done = 1'b1;
        #1;
        check("t5b_tmo_suppressed", bus.tmo_err, 0);
        @(negedge clk_sys);
        bus.done = 1'b0;
        check("t5b_state_idle", dbg_state, S_IDLE);
        check("t5b_deficit0_kept", def_of(0), 1472);
        check("t5b_ptr_kept", dbg_ptr, 0);
        wait_vld(10, cyc, found);
        check("t5b_regrant", bus.grant, 4'b0001);
        check("t5b_deficit0_next", def_of(0), 1408);

        // Reset during WAIT
        do_reset();
        bus.port_en = 4'b1111;
        set_lens(64, 64, 64, 64);
        bus.req = 4'b0010;
        wait_vld(10, cyc, found);
        check("t6_found", found, 1);
        check("t6_grant", bus.grant, 4'b0010);
        check("t6_deficit1", def_of(1), 1472);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_sys = 1'b1;
        @(negedge clk_sys);
        check("t6_grant_zero", bus.grant, 0);
        check("t6_grant_bin_zero", bus.grant_bin, 0);
        check("t6_vld_zero", bus.grant_vld, 0);
        check("t6_busy_zero", bus.busy, 0);
        check("t6_tmo_zero", bus.tmo_err, 0);
        for (int p = 0; p < NPORT; p++) check("t6_deficit_zero", def_of(p), 0);
        rst_sys = 1'b0;
        bus.req = 4'b1111;
        wait_vld(10, cyc, found);
        check("t6_restart_found", found, 1);
        check("t6_restart_latency", cyc, 2);
        check("t6_restart_port0", bus.grant, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
